// File: rtl/lamp_pkg.sv
// Shared definitions for the lamp controller: board geometry, default widths,
// shifter state encoding and a width helper.
package lamp_pkg;

  localparam int unsigned c_boardchannels = 32;
  localparam int unsigned c_def_bpc       = 12;
  localparam int unsigned c_def_ledboards = 30;
  localparam int unsigned c_def_clkdiv    = 4;

  typedef enum logic [2:0] {
    s_idle  = 3'd0,
    s_addr  = 3'd1,
    s_load  = 3'd2,
    s_shift = 3'd3,
    s_latch = 3'd4,
    s_done  = 3'd5
  } state_e;

  // Counter width for a range of n values; never below one bit so that
  // degenerate ranges (n == 1) still give a legal vector.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_tick.sv
// Divider for the serial shift clock: counts c_clkdiv enabled cycles and
// flags the last one. Cleared by the shifter when a new word is loaded.
module clk_tick
  import lamp_pkg::*;
#(
  parameter int unsigned c_clkdiv = c_def_clkdiv
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned          c_w    = clog2_min1(c_clkdiv);
  localparam logic [c_w-1:0]       c_last = c_w'(c_clkdiv - 1);

  logic [c_w-1:0] div_q;
  logic [c_w-1:0] div_d;

  // Terminal count only when counting; with c_clkdiv == 1 every enabled cycle is terminal.
  assign o_tc = i_en && (div_q == c_last);

  // Next count: clear wins, otherwise wrap at the terminal count.
  always_comb begin
    div_d = div_q;
    if (i_clr) begin
      div_d = '0;
    end else if (i_en) begin
      div_d = (div_q == c_last) ? '0 : div_q + 1'b1;
    end
  end

  // Divider count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/led_shifter.sv
// Serialiser from the current frame buffer to the LED-board daisy chain.
// Channels are read from the top address down to 0, each word sent MSB first
// with a divided shift clock, then the chain is latched and o_drq pulses once.
module led_shifter
  import lamp_pkg::*;
#(
  parameter int unsigned c_ledboards = c_def_ledboards,
  parameter int unsigned c_channels  = c_ledboards * c_boardchannels,
  parameter int unsigned c_addr_w    = $clog2(c_channels),
  parameter int unsigned c_bpc       = c_def_bpc,
  parameter int unsigned c_clkdiv    = c_def_clkdiv
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  output logic [c_addr_w-1:0] o_raddr,
  input  logic [c_bpc-1:0]    i_data,
  output logic                o_sclk,
  output logic                o_sdata,
  output logic                o_latch,
  output logic                o_drq,
  output logic                o_busy
);

  localparam int unsigned         c_bit_w     = clog2_min1(c_bpc);
  localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(c_bpc - 1);
  localparam logic [c_addr_w-1:0] c_addr_last = c_addr_w'(c_channels - 1);

  state_e              state_q, state_d;
  logic [c_addr_w-1:0] addr_q, addr_d;
  logic [c_bit_w-1:0]  bit_q, bit_d;
  logic                phase_q, phase_d;
  logic [c_bpc-1:0]    shift_q, shift_d;

  logic sclk_q, sclk_d;
  logic sdata_q, sdata_d;
  logic latch_q, latch_d;
  logic drq_q, drq_d;
  logic busy_q, busy_d;

  logic tick_en;
  logic tick_clr;
  logic tick;

  // The same divider times both shift half-periods and the latch pulse.
  assign tick_en  = (state_q == s_shift) || (state_q == s_latch);
  assign tick_clr = (state_q == s_load);

  clk_tick #(
    .c_clkdiv (c_clkdiv)
  ) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (tick_clr),
    .i_en    (tick_en),
    .o_tc    (tick)
  );

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= s_idle;
      addr_q  <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      shift_q <= shift_d;
    end
  end

  // Next-state and datapath sequencing through one frame.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    shift_d = shift_q;
    unique case (state_q)
      s_idle: begin
        if (i_start) begin
          addr_d  = c_addr_last;
          state_d = s_addr;
        end
      end
      s_addr: begin
        state_d = s_load;
      end
      s_load: begin
        shift_d = i_data;
        bit_d   = '0;
        phase_d = 1'b0;
        state_d = s_shift;
      end
      s_shift: begin
        if (tick) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            shift_d = shift_q << 1;
            if (bit_q == c_bit_last) begin
              bit_d = '0;
              if (addr_q == '0) begin
                state_d = s_latch;
              end else begin
                addr_d  = addr_q - 1'b1;
                state_d = s_addr;
              end
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
      s_latch: begin
        if (tick) begin
          state_d = s_done;
        end
      end
      s_done: begin
        state_d = s_idle;
      end
      default: begin
        state_d = s_idle;
      end
    endcase
  end

  // Output decode from the next state so the pins are flop outputs aligned with state_q.
  always_comb begin
    sclk_d  = (state_d == s_shift) && phase_d;
    sdata_d = (state_d == s_shift) ? shift_d[c_bpc-1] : sdata_q;
    latch_d = (state_d == s_latch);
    drq_d   = (state_d == s_done);
    busy_d  = (state_d != s_idle);
  end

  // Registered pin drivers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      latch_q <= 1'b0;
      drq_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      latch_q <= latch_d;
      drq_q   <= drq_d;
      busy_q  <= busy_d;
    end
  end

  assign o_raddr = addr_q;
  assign o_sclk  = sclk_q;
  assign o_sdata = sdata_q;
  assign o_latch = latch_q;
  assign o_drq   = drq_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_led_shifter.sv
// Bench for led_shifter: two instances (clkdiv 1 and 4, one board each) share
// a frame-buffer model; expectations are queued at stimulus time and a
// per-instance monitor decodes the serial pins and compares.
module tb_led_shifter;

  localparam int NCH = 32;
  localparam int BPC = 12;

  typedef struct packed {
    logic [4:0]  addr;
    logic [11:0] word;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start_w;
  logic [4:0]  raddr_w [2];
  logic [11:0] data_r  [2];
  logic [1:0]  sclk_w, sdata_w, latch_w, drq_w, busy_w;

  logic [11:0] ram [NCH];

  ent_t word_q [2][$];
  int   frm_q  [2][$];
  int   frames_exp  [2];
  int   frames_done [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_shifter #(.c_ledboards(1), .c_clkdiv(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_w[0]), .o_raddr(raddr_w[0]),
    .i_data(data_r[0]), .o_sclk(sclk_w[0]), .o_sdata(sdata_w[0]),
    .o_latch(latch_w[0]), .o_drq(drq_w[0]), .o_busy(busy_w[0])
  );

  led_shifter #(.c_ledboards(1), .c_clkdiv(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_w[1]), .o_raddr(raddr_w[1]),
    .i_data(data_r[1]), .o_sclk(sclk_w[1]), .o_sdata(sdata_w[1]),
    .o_latch(latch_w[1]), .o_drq(drq_w[1]), .o_busy(busy_w[1])
  );

  // Synchronous-read frame buffer: data one cycle after address.
  always @(posedge clk) begin
    data_r[0] <= ram[raddr_w[0]];
    data_r[1] <= ram[raddr_w[1]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: one frame sends channels NCH-1..0 with their buffer contents.
  task automatic push_frame(input int id, input int gap_exp);
    for (int ch = NCH - 1; ch >= 0; ch--) begin
      ent_t e;
      e.addr = 5'(ch);
      e.word = ram[ch];
      word_q[id].push_back(e);
    end
    frm_q[id].push_back(gap_exp);
    frames_exp[id]++;
  endtask

  task automatic monitor(input int id);
    int div, run, bitpos, busy_len, lat_len, lat_pulses, drq_cnt, rises, gap, wcount;
    bit in_frame, p_sclk, p_busy, p_lat;
    logic [11:0] word;
    ent_t cur;
    div = (id == 0) ? 1 : 4;
    in_frame = 0; p_sclk = 0; p_busy = 0; p_lat = 0; gap = 0;
    run = 0; bitpos = 0; busy_len = 0; lat_len = 0; lat_pulses = 0;
    drq_cnt = 0; rises = 0; wcount = 0; word = '0; cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 0; p_sclk = 0; p_busy = 0; p_lat = 0; gap = 0;
        continue;
      end
      if (busy_w[id] && !p_busy) begin
        in_frame = 1; run = 0; bitpos = 0; busy_len = 0; lat_len = 0;
        lat_pulses = 0; drq_cnt = 0; rises = 0; wcount = 0;
        check($sformatf("dut%0d frame expected", id), 64'(frm_q[id].size() > 0), 1);
        if (frm_q[id].size() > 0) begin
          int g;
          g = frm_q[id].pop_front();
          if (g >= 0) check($sformatf("dut%0d idle gap", id), 64'(gap), 64'(g));
        end
      end
      if (in_frame) begin
        if (busy_w[id]) busy_len++;
        if (drq_w[id]) drq_cnt++;
        if (latch_w[id]) begin
          lat_len++;
          if (!p_lat) lat_pulses++;
        end
        if (sclk_w[id] && !p_sclk) begin
          check($sformatf("dut%0d sclk low len", id), 64'(run),
                64'((bitpos == 0) ? div + 2 : div));
          if (bitpos == 0) begin
            check($sformatf("dut%0d channel expected", id), 64'(word_q[id].size() > 0), 1);
            cur = (word_q[id].size() > 0) ? word_q[id].pop_front() : '0;
            check($sformatf("dut%0d raddr", id), 64'(raddr_w[id]), 64'(cur.addr));
          end
          word = {word[10:0], sdata_w[id]};
          bitpos++;
          rises++;
          if (bitpos == BPC) begin
            check($sformatf("dut%0d word ch%0d", id, cur.addr), 64'(word), 64'(cur.word));
            bitpos = 0;
            wcount++;
          end
          run = 1;
        end else if (!sclk_w[id] && p_sclk) begin
          check($sformatf("dut%0d sclk high len", id), 64'(run), 64'(div));
          run = 1;
        end else begin
          run++;
        end
        if (!busy_w[id] && p_busy) begin
          check($sformatf("dut%0d busy len", id), 64'(busy_len),
                64'(NCH * (2 + 2 * div * BPC) + div + 1));
          check($sformatf("dut%0d latch len", id), 64'(lat_len), 64'(div));
          check($sformatf("dut%0d latch pulses", id), 64'(lat_pulses), 1);
          check($sformatf("dut%0d drq cycles", id), 64'(drq_cnt), 1);
          check($sformatf("dut%0d sclk rises", id), 64'(rises), 64'(NCH * BPC));
          check($sformatf("dut%0d words", id), 64'(wcount), 64'(NCH));
          frames_done[id]++;
          in_frame = 0;
          gap = 1;
        end
      end else if (!busy_w[id]) begin
        gap++;
      end
      p_sclk = sclk_w[id];
      p_busy = busy_w[id];
      p_lat  = latch_w[id];
    end
  endtask

  task automatic pulse_start(input logic [1:0] which);
    @(negedge clk);
    start_w = which;
    @(negedge clk);
    start_w = 2'b00;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy_w != 2'b00 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("idle within bound", 64'(busy_w), 0);
  endtask

  task automatic run_frame(input logic [1:0] which);
    for (int i = 0; i < 2; i++) if (which[i]) push_frame(i, -1);
    pulse_start(which);
    wait_idle();
  endtask

  task automatic held_start(input int id, input int k);
    int n, t;
    for (int f = 0; f < k; f++) push_frame(id, (f == 0) ? -1 : 1);
    @(negedge clk);
    start_w[id] = 1'b1;
    n = 0; t = 0;
    while (n < k && t < k * 4000) begin
      @(negedge clk);
      t++;
      if (drq_w[id]) n++;
    end
    start_w[id] = 1'b0;
    check($sformatf("dut%0d held-start frames", id), 64'(n), 64'(k));
    wait_idle();
  endtask

  task automatic fill_random();
    for (int n = 0; n < NCH; n++) ram[n] = 12'($urandom);
  endtask

  task automatic check_outs_zero(input string tag);
    for (int i = 0; i < 2; i++)
      check($sformatf("dut%0d %s outputs", i, tag),
            64'({raddr_w[i], sclk_w[i], sdata_w[i], latch_w[i], drq_w[i], busy_w[i]}), 0);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    start_w = 2'b00;
    frames_exp = '{0, 0};
    frames_done = '{0, 0};
    for (int n = 0; n < NCH; n++) ram[n] = 12'(n);
    fork
      monitor(0);
      monitor(1);
    join_none
    repeat (3) @(negedge clk);
    check_outs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Ramp content: every address distinct, so skips or repeats show up.
    run_frame(2'b11);

    // Known pattern on the first channel sent.
    fill_random();
    ram[31] = 12'hA5C;
    run_frame(2'b11);

    // A second start mid-frame must be dropped.
    fill_random();
    push_frame(0, -1);
    push_frame(1, -1);
    pulse_start(2'b11);
    repeat (300) @(negedge clk);
    pulse_start(2'b11);
    wait_idle();
    repeat (10) @(negedge clk);
    check("no extra frame after mid-frame start", 64'(busy_w), 0);
    run_frame(2'b11);

    // Start held high: back-to-back frames with a single idle cycle.
    fill_random();
    held_start(0, 3);
    held_start(1, 2);

    // Asynchronous reset in the middle of channel 10, bit 5 of the fast instance.
    fill_random();
    push_frame(0, -1);
    push_frame(1, -1);
    pulse_start(2'b11);
    t = 0;
    while (raddr_w[0] != 5'd10 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("reached channel 10", 64'(raddr_w[0]), 10);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outs_zero("async reset");
    for (int i = 0; i < 2; i++) begin
      word_q[i].delete();
      frm_q[i].delete();
      frames_exp[i]--;
    end
    repeat (2) @(negedge clk);
    check_outs_zero("held reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_outs_zero("post reset");
    fill_random();
    run_frame(2'b11);

    // A further random frame on each instance.
    fill_random();
    run_frame(2'b11);

    repeat (5) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d frames completed", i), 64'(frames_done[i]), 64'(frames_exp[i]));
      check($sformatf("dut%0d words left", i), 64'(word_q[i].size()), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
